// File: rtl/stream_line_reframer.sv
// AXI4-Stream video re-framer: regenerates tlast/tuser from a latched line/frame geometry,
// aligns to upstream start-of-frame and flags upstream framing mismatches.
module stream_line_reframer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CHANNELS   = 3,
  parameter int unsigned CNT_WIDTH  = 12
) (
  input  logic                           pixel_clk,
  input  logic                           rst,
  input  logic [CNT_WIDTH-1:0]           line_len,
  input  logic [CNT_WIDTH-1:0]           frame_rows,
  input  logic [DATA_WIDTH*CHANNELS-1:0] s_axis_tdata,
  input  logic                           s_axis_tlast,
  input  logic                           s_axis_tuser,
  input  logic                           s_axis_tvalid,
  output logic                           s_axis_tready,
  output logic [DATA_WIDTH*CHANNELS-1:0] m_axis_tdata,
  output logic                           m_axis_tlast,
  output logic                           m_axis_tuser,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic                           frame_done,
  output logic                           tlast_err,
  output logic                           sof_err
);

  localparam int unsigned TdataWidth = DATA_WIDTH * CHANNELS;
  localparam logic [CNT_WIDTH-1:0] CntOne = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {StUnsync, StActive} state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] x_cnt_q, x_cnt_d;
  logic [CNT_WIDTH-1:0] y_cnt_q, y_cnt_d;
  logic [CNT_WIDTH-1:0] len_q, rows_q;

  logic                 accept;
  logic [CNT_WIDTH-1:0] len_new, rows_new;
  logic [CNT_WIDTH-1:0] cur_len, cur_rows;
  logic [CNT_WIDTH-1:0] x_pos, y_pos;
  logic                 x_last, y_last;
  logic                 active_beat;
  logic                 out_last, out_user;
  logic                 frame_hit, tlast_hit, sof_hit;

  assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
  assign accept        = s_axis_tvalid && s_axis_tready;

  // State register
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      state_q <= StUnsync;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: any accepted start-of-frame locks (or re-locks) the framing
  always_comb begin
    state_d = state_q;
    if (accept && s_axis_tuser) begin
      state_d = StActive;
    end
  end

  // Beat decode: position and regenerated framing for the beat presented on the input
  always_comb begin
    len_new     = (line_len == '0) ? CntOne : line_len;
    rows_new    = (frame_rows == '0) ? CntOne : frame_rows;
    cur_len     = s_axis_tuser ? len_new : len_q;
    cur_rows    = s_axis_tuser ? rows_new : rows_q;
    x_pos       = s_axis_tuser ? '0 : x_cnt_q;
    y_pos       = s_axis_tuser ? '0 : y_cnt_q;
    x_last      = (x_pos == cur_len - CntOne);
    y_last      = (y_pos == cur_rows - CntOne);
    // The syncing tuser beat itself is already framed as position (0,0)
    active_beat = (state_q == StActive) || s_axis_tuser;
    out_last    = active_beat && x_last;
    out_user    = active_beat && (x_pos == '0) && (y_pos == '0);
    frame_hit   = active_beat && x_last && y_last;
    tlast_hit   = (state_q == StActive) && (s_axis_tlast != x_last);
    sof_hit     = (state_q == StActive) && s_axis_tuser &&
                  ((x_cnt_q != '0) || (y_cnt_q != '0));
  end

  always_comb begin
    x_cnt_d = x_cnt_q;
    y_cnt_d = y_cnt_q;
    if (accept && active_beat) begin
      if (x_last) begin
        x_cnt_d = '0;
        y_cnt_d = y_last ? '0 : y_pos + CntOne;
      end else begin
        x_cnt_d = x_pos + CntOne;
        y_cnt_d = y_pos;
      end
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      x_cnt_q       <= '0;
      y_cnt_q       <= '0;
      len_q         <= CntOne;
      rows_q        <= CntOne;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      m_axis_tvalid <= 1'b0;
      frame_done    <= 1'b0;
      tlast_err     <= 1'b0;
      sof_err       <= 1'b0;
    end else begin
      x_cnt_q    <= x_cnt_d;
      y_cnt_q    <= y_cnt_d;
      frame_done <= accept && frame_hit;
      tlast_err  <= accept && tlast_hit;
      sof_err    <= accept && sof_hit;
      if (accept && s_axis_tuser) begin
        len_q  <= len_new;
        rows_q <= rows_new;
      end
      if (accept) begin
        m_axis_tdata  <= s_axis_tdata[TdataWidth-1:0];
        m_axis_tlast  <= out_last;
        m_axis_tuser  <= out_user;
        m_axis_tvalid <= 1'b1;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_line_reframer.sv
// Directed self-checking bench for stream_line_reframer (default 8x3 pixel, 12-bit counters).
module tb_stream_line_reframer;

  logic        pixel_clk = 1'b0;
  logic        rst;
  logic [11:0] line_len, frame_rows;
  logic [23:0] s_tdata;
  logic        s_tlast, s_tuser, s_tvalid, s_tready;
  logic [23:0] m_tdata;
  logic        m_tlast, m_tuser, m_tvalid, m_tready;
  logic        frame_done, tlast_err, sof_err;

  int n_vec = 0;
  int n_err = 0;
  int nbeat = 0;

  always #5 pixel_clk = ~pixel_clk;

  stream_line_reframer dut (
    .pixel_clk     (pixel_clk),
    .rst           (rst),
    .line_len      (line_len),
    .frame_rows    (frame_rows),
    .s_axis_tdata  (s_tdata),
    .s_axis_tlast  (s_tlast),
    .s_axis_tuser  (s_tuser),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tlast  (m_tlast),
    .m_axis_tuser  (m_tuser),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .frame_done    (frame_done),
    .tlast_err     (tlast_err),
    .sof_err       (sof_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    s_tvalid = 1'b0;
    s_tuser  = 1'b0;
    s_tlast  = 1'b0;
    @(posedge pixel_clk);
    #1;
    rst = 1'b0;
  endtask

  // One accepted beat under continuous ready; outputs checked one cycle later
  task automatic beat(input logic [23:0] d, input logic tu, input logic tl, input logic el,
                      input logic eu, input logic efd, input logic ete, input logic ese);
    s_tdata  = d;
    s_tuser  = tu;
    s_tlast  = tl;
    s_tvalid = 1'b1;
    @(posedge pixel_clk);
    #1;
    check($sformatf("b%0d tvalid", nbeat), m_tvalid, 1);
    check($sformatf("b%0d tdata", nbeat), m_tdata, d);
    check($sformatf("b%0d tlast", nbeat), m_tlast, el);
    check($sformatf("b%0d tuser", nbeat), m_tuser, eu);
    check($sformatf("b%0d frame_done", nbeat), frame_done, efd);
    check($sformatf("b%0d tlast_err", nbeat), tlast_err, ete);
    check($sformatf("b%0d sof_err", nbeat), sof_err, ese);
    nbeat++;
  endtask

  initial begin
    int fd_cnt;
    int send_idx, recv_idx, cycles;
    logic acc;
    m_tready   = 1'b1;
    line_len   = 12'd8;
    frame_rows = 12'd4;
    s_tdata    = '0;
    do_reset();
    do_reset();
    check("reset tvalid", m_tvalid, 0);
    check("reset tdata", m_tdata, 0);
    check("reset tlast", m_tlast, 0);
    check("reset tuser", m_tuser, 0);
    check("reset pulses", {frame_done, tlast_err, sof_err}, 0);
    check("reset tready", s_tready, 1);

    // 4 frames of 8x4, tuser only on the very first beat
    fd_cnt = 0;
    for (int i = 0; i < 128; i++) begin
      beat(24'h100 + 24'(i), i == 0, (i % 8) == 7, (i % 8) == 7, (i % 32) == 0,
           (i % 32) == 31, 1'b0, 1'b0);
      if (frame_done) fd_cnt++;
    end
    check("frame_done count", fd_cnt, 4);

    // Pre-sync beats pass unframed and do not advance position
    do_reset();
    for (int i = 0; i < 3; i++) beat(24'h200 + 24'(i), 1'b0, i == 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < 9; j++)
      beat(24'h210 + 24'(j), j == 0, j == 7, j == 7, j == 0, 1'b0, 1'b0, 1'b0);

    // Early tuser at (3,1) realigns and flags sof_err
    do_reset();
    for (int j = 0; j < 11; j++)
      beat(24'h300 + 24'(j), j == 0, (j % 8) == 7, (j % 8) == 7, j == 0, 1'b0, 1'b0, 1'b0);
    beat(24'h3AA, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int j = 1; j < 9; j++)
      beat(24'h310 + 24'(j), 1'b0, j == 7, j == 7, 1'b0, 1'b0, 1'b0, 1'b0);

    // Upstream tlast one pixel early
    do_reset();
    for (int j = 0; j < 6; j++)
      beat(24'h400 + 24'(j), j == 0, 1'b0, 1'b0, j == 0, 1'b0, 1'b0, 1'b0);
    beat(24'h406, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    beat(24'h407, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Zero geometry clamps to 1x1: every beat is a whole frame
    do_reset();
    line_len   = 12'd0;
    frame_rows = 12'd0;
    for (int j = 0; j < 4; j++)
      beat(24'h500 + 24'(j), j == 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

    // Random downstream backpressure, 5x3 geometry
    do_reset();
    line_len   = 12'd5;
    frame_rows = 12'd3;
    send_idx   = 0;
    recv_idx   = 0;
    cycles     = 0;
    s_tvalid   = 1'b1;
    s_tdata    = 24'h600000;
    s_tuser    = 1'b1;
    s_tlast    = 1'b0;
    while (recv_idx < 45 && cycles < 2000) begin
      m_tready = 1'($urandom_range(0, 1));
      #1;
      if (m_tvalid) begin
        check($sformatf("r%0d tdata", recv_idx), m_tdata, 24'h600000 + 24'(recv_idx));
        check($sformatf("r%0d tlast", recv_idx), m_tlast, (recv_idx % 5) == 4);
        check($sformatf("r%0d tuser", recv_idx), m_tuser, (recv_idx % 15) == 0);
        if (m_tready) recv_idx++;
      end
      acc = s_tready;
      @(posedge pixel_clk);
      #1;
      cycles++;
      if (acc) send_idx++;
      s_tdata = 24'h600000 + 24'(send_idx);
      s_tuser = (send_idx == 0);
      s_tlast = (send_idx % 5) == 4;
    end
    check("rand beats received", recv_idx, 45);
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    @(posedge pixel_clk);
    #1;

    // Reset mid-line discards the held beat and unlocks framing
    do_reset();
    line_len   = 12'd8;
    frame_rows = 12'd4;
    for (int j = 0; j < 4; j++)
      beat(24'h700 + 24'(j), j == 0, 1'b0, 1'b0, j == 0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge pixel_clk);
    #1;
    rst = 1'b0;
    check("midrst tvalid", m_tvalid, 0);
    check("midrst tdata", m_tdata, 0);
    check("midrst tlast/tuser", {m_tlast, m_tuser}, 0);
    check("midrst pulses", {frame_done, tlast_err, sof_err}, 0);
    for (int j = 0; j < 10; j++) beat(24'h710 + 24'(j), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    line_len   = 12'd16;
    frame_rows = 12'd2;
    for (int j = 0; j < 34; j++) begin
      beat(24'h800 + 24'(j), j == 0, (j % 16) == 15, (j % 16) == 15, (j % 32) == 0,
           j == 31, 1'b0, 1'b0);
      if (j == 2) line_len = 12'd4;
    end

    s_tvalid = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/stream_line_reframer.md
Name: stream_line_reframer

Overview:
- Parametrised AXI4-Stream video re-framer with backpressure. It regenerates tlast every line_len accepted beats and regenerates tuser at each frame start every frame_rows lines.
- It aligns to input tuser and flags framing mismatches.
- It sits between capture/ISP stages and VDMA. This lets downstream blocks rely on a clean line and frame structure regardless of upstream tlast quality.
- Multi-channel (e.g. RGB) pixels travel together as one beat.

Parameters:
- DATA_WIDTH, 8, bits per channel.
- CHANNELS, 3, channels per pixel; tdata width = DATA_WIDTH*CHANNELS.
- CNT_WIDTH, 12, width of the line-length and row counters and the config inputs.

Ports:
- pixel_clk  in  1  pixel clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- line_len  in  CNT_WIDTH  pixels per line; sampled only on a frame-start beat.
- frame_rows  in  CNT_WIDTH  lines per frame; sampled only on a frame-start beat.
- s_axis_tdata  in  DATA_WIDTH*CHANNELS  input pixel.
- s_axis_tlast  in  1  upstream end-of-line; used only for checking.
- s_axis_tuser  in  1  upstream start-of-frame.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- m_axis_tdata  out  DATA_WIDTH*CHANNELS  output pixel.
- m_axis_tlast  out  1  regenerated end-of-line.
- m_axis_tuser  out  1  regenerated start-of-frame.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- frame_done  out  1  1-cycle pulse, last beat of a frame loaded to output.
- tlast_err  out  1  1-cycle pulse, accepted s_axis_tlast differs from regenerated tlast (ACTIVE state only).
- sof_err  out  1  1-cycle pulse, s_axis_tuser accepted in ACTIVE while position is not (0,0).

Behaviour:
- Reset: rst high at a rising edge clears the following: m_axis_tvalid/tlast/tuser = 0, m_axis_tdata = 0, all pulses = 0, x_cnt = y_cnt = 0, latched L = H = 1, state = UNSYNC. Reset mid-frame discards the output-register beat.
- Handshake:
  - Single output register stage.
  - s_axis_tready = !m_axis_tvalid || m_axis_tready (combinational).
  - accept = s_axis_tvalid && s_axis_tready.
  - On accept, the output register loads tdata/tlast/tuser and m_axis_tvalid=1.
  - Without accept, if m_axis_tready is high, m_axis_tvalid clears; otherwise the output holds stable.
  - Latency is 1 cycle; throughput is 1 beat/cycle under continuous ready.
- Config clamp: L = max(line_len,1) and H = max(frame_rows,1), latched on the accepted beat with s_axis_tuser=1. That beat already uses the new L/H.
- UNSYNC state:
  - Accepted beats pass with m_axis_tlast=0 and m_axis_tuser=0; counters hold; no error pulses.
  - An accepted beat with s_axis_tuser=1 goes to ACTIVE and is treated as position (0,0).
- ACTIVE state:
  - The position of the accepted beat is (x,y) = (0,0) if s_axis_tuser=1, else (x_cnt,y_cnt).
  - Outputs: m_axis_tuser = (x==0 && y==0); m_axis_tlast = (x==L-1).
  - Counter update:
    - If x==L-1 and y==H-1: next (0,0) and pulse frame_done.
    - Else if x==L-1: next (0,y+1).
    - Else: next (x+1,y).
  - After a frame ends the block freewheels: the next beat gets tuser=1 even without input tuser.
  - An early s_axis_tuser realigns to (0,0) in the same beat and pulses sof_err, if the pre-realign position was not (0,0).
  - Input tuser exactly at the freewheel (0,0) position is accepted silently.
- Error and status pulses:
  - tlast_err is evaluated using the post-realign x.
  - Pulses assert in the cycle after the accept, aligned with the output register load. They never assert without an accept.
- Counter widths: counters are CNT_WIDTH bits; compares use latched L-1/H-1 at full width, with no wrap at 2^CNT_WIDTH.
- Simultaneous events: tuser and tlast on the same beat (L=1) gives both outputs 1. If H=1 as well, frame_done pulses every beat.
- line_len/frame_rows changes mid-frame have no effect until the next input tuser.

Test Plan:
- Reset, then 4 frames with L=8, H=4, input tuser only on the first beat, continuous ready. Required: m_axis_tlast on beats 7,15,…; m_axis_tuser on beats 0,32,64,96; frame_done 4 times; no errors.
- Beats before the first tuser, then tuser. Required: pre-sync beats emerge with tlast=tuser=0 and do not advance counters; first tuser beat emits tuser=1; latency exactly 1 cycle.
- m_axis_tready toggled randomly (50%) with L=5, H=3. Required: no data loss or duplication; output held stable while stalled; tlast every 5th transferred beat.
- Input tuser injected at x=3,y=1 (L=8, H=4). Required: sof_err pulses once; that beat emits tuser=1; next tlast after 8 beats.
- Upstream tlast at x=6 with L=8. Required: tlast_err pulses once; m_axis_tlast stays at x=7. Separately, L=1, H=1: every beat has tlast=tuser=1 and frame_done pulses every beat.
- rst asserted mid-line with m_axis_tvalid=1. Required: next cycle all outputs 0 and state UNSYNC; a new frame re-latches L=16 and behaves correctly.
